// File: rtl/sys_panel_pkg.sv
// sys_panel_pkg: shared constants and 7-segment decoding for the front-panel controller.
package sys_panel_pkg;
    localparam int SYNC_STAGES = 2;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO = 7'h40;
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction
endpackage

// File: rtl/sys_key_debounce.sv
// sys_key_debounce: synchronises one active-low key, debounces it and pulses once per accepted press.
module sys_key_debounce
    import sys_panel_pkg::*;
#(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pulse
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sr;
    logic [CW-1:0] cnt;
    logic lvl, s, acc;
    assign s = sr[SYNC_STAGES-1];
    // a bounce back to the accepted level restarts the count
    assign acc = (s != lvl) && (cnt == CW'(DB_CYCLES - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
            cnt <= '0;
            lvl <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], ~key_n};
            cnt <= (s == lvl || acc) ? '0 : cnt + CW'(1);
            lvl <= acc ? s : lvl;
            pulse <= acc & s;
        end
    end
endmodule

// File: rtl/sys_panel_ctrl.sv
// sys_panel_ctrl: front-panel keys/switches/LEDs/7-seg to core glue with step enable and PC-load handshake.
// Define SYS_AUTO_RUN_EN to build the sw_run auto-step divider.
module sys_panel_ctrl
    import sys_panel_pkg::*;
#(
    parameter int NKEY      = 4,
    parameter int DB_CYCLES = 250000,
    parameter int PCW       = 8,
    parameter int NCH       = 8,
    parameter int DW        = 18,
    parameter int NHEX      = 2,
    parameter int RUN_DIV   = 25000000
) (
    input  logic                    SYS_clk,
    input  logic                    SYS_rst,
    input  logic [NKEY-1:0]         key_n,
    input  logic                    sw_run,
    input  logic                    sw_load,
    input  logic [PCW-1:0]          sw_pc_val,
    input  logic [$clog2(NCH)-1:0]  out_sel,
    input  logic [NCH*DW-1:0]       dbg_bus,
    output logic                    step_en,
    output logic [NKEY-1:0]         key_pulse,
    output logic                    pc_load_valid,
    output logic [PCW-1:0]          pc_load_val,
    input  logic                    pc_load_ready,
    output logic [DW-1:0]           leds,
    output logic [NHEX*7-1:0]       hex_n
);
    localparam int SW = $clog2(NCH);
    logic [SYNC_STAGES-1:0] ld_sr;
    logic [PCW-1:0] pv_sr [SYNC_STAGES];
    logic ld_prev, ld_s;
    logic [DW-1:0] ch [2**SW];

    for (genvar k = 0; k < NKEY; k++) begin : g_key
        sys_key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk(SYS_clk), .rst(SYS_rst), .key_n(key_n[k]), .pulse(key_pulse[k])
        );
    end

    assign ld_s = ld_sr[SYNC_STAGES-1];
    always_ff @(posedge SYS_clk or posedge SYS_rst) begin
        if (SYS_rst) begin
            ld_sr <= '0;
            ld_prev <= 1'b0;
            pv_sr <= '{default: '0};
            pc_load_valid <= 1'b0;
            pc_load_val <= '0;
        end else begin
            ld_sr <= {ld_sr[SYNC_STAGES-2:0], sw_load};
            ld_prev <= ld_s;
            pv_sr[0] <= sw_pc_val;
            for (int i = 1; i < SYNC_STAGES; i++) pv_sr[i] <= pv_sr[i-1];
            if (!pc_load_valid && ld_s && !ld_prev) begin
                pc_load_valid <= 1'b1;
                pc_load_val <= pv_sr[SYNC_STAGES-1];
            end else if (pc_load_valid && pc_load_ready) begin
                pc_load_valid <= 1'b0;
            end
        end
    end

    // selector codes past the last channel read as zero
    for (genvar c = 0; c < 2**SW; c++) begin : g_ch
        if (c < NCH) begin : g_real
            assign ch[c] = dbg_bus[c*DW +: DW];
        end else begin : g_pad
            assign ch[c] = '0;
        end
    end

    always_ff @(posedge SYS_clk or posedge SYS_rst) begin
        if (SYS_rst) leds <= '0;
        else leds <= ch[out_sel];
    end

    for (genvar d = 0; d < NHEX; d++) begin : g_hex
        assign hex_n[d*7 +: 7] = seg7(4'(leds >> (4*d)));
    end

`ifdef SYS_AUTO_RUN_EN
    logic [SYNC_STAGES-1:0] run_sr;
    logic run, run_prev;
    logic [31:0] div;
    assign run = run_sr[SYNC_STAGES-1];
    always_ff @(posedge SYS_clk or posedge SYS_rst) begin
        if (SYS_rst) begin
            run_sr <= '0;
            run_prev <= 1'b0;
            div <= '0;
        end else begin
            run_sr <= {run_sr[SYNC_STAGES-2:0], sw_run};
            run_prev <= run;
            if (run && !run_prev) div <= '0;
            else if (run) div <= (div == 32'(RUN_DIV - 1)) ? '0 : div + 32'd1;
        end
    end
    // run_prev masks a stale wrap value in the cycle the divider is cleared
    assign step_en = run ? (run_prev && div == 32'(RUN_DIV - 1) && !pc_load_valid)
                         : (key_pulse[0] && !pc_load_valid);
`else
    logic unused_run;
    assign unused_run = sw_run ^ (RUN_DIV == 0);
    assign step_en = key_pulse[0] & ~pc_load_valid;
`endif
endmodule

// File: tb/tb_sys_panel_ctrl.sv
// tb_sys_panel_ctrl: vector tables, random display/key traffic and handshake sequences for sys_panel_ctrl.
module tb_sys_panel_ctrl;
    localparam int DW = 18;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] key_n = '1;
    logic sw_run = 1'b0, sw_load = 1'b0, ready = 1'b0;
    logic [7:0] pcv = '0;
    logic [2:0] sel8 = '0;
    logic [3:0] sel12 = '0;
    logic [DW-1:0] chan [12] = '{default: '0};
    logic [12*DW-1:0] dbg12;
    logic [8*DW-1:0] dbg8;
    logic step_en, valid, step12, valid12;
    logic [3:0] kp, kp12;
    logic [7:0] val, val12;
    logic [DW-1:0] leds, leds12;
    logic [13:0] hex, hex12;
    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int total = 0, bad = 0;
    int n_step = 0;
    int n_kp [4] = '{default: 0};

    typedef struct {
        int sel;
        logic [DW-1:0] val;
        logic [13:0] hex;
    } dvec_t;
    dvec_t dv [4];

    for (genvar c = 0; c < 12; c++) begin : g_bus
        assign dbg12[c*DW +: DW] = chan[c];
    end
    assign dbg8 = dbg12[8*DW-1:0];

    always #5 clk = ~clk;

    sys_panel_ctrl #(.NKEY(4), .DB_CYCLES(8), .PCW(8), .NCH(8), .DW(DW), .NHEX(2), .RUN_DIV(5)) dut (
        .SYS_clk(clk), .SYS_rst(rst), .key_n(key_n), .sw_run(sw_run), .sw_load(sw_load),
        .sw_pc_val(pcv), .out_sel(sel8), .dbg_bus(dbg8), .step_en(step_en), .key_pulse(kp),
        .pc_load_valid(valid), .pc_load_val(val), .pc_load_ready(ready), .leds(leds), .hex_n(hex)
    );

    sys_panel_ctrl #(.NKEY(4), .DB_CYCLES(8), .PCW(8), .NCH(12), .DW(DW), .NHEX(2), .RUN_DIV(5)) dut12 (
        .SYS_clk(clk), .SYS_rst(rst), .key_n(key_n), .sw_run(sw_run), .sw_load(sw_load),
        .sw_pc_val(pcv), .out_sel(sel12), .dbg_bus(dbg12), .step_en(step12), .key_pulse(kp12),
        .pc_load_valid(valid12), .pc_load_val(val12), .pc_load_ready(ready), .leds(leds12), .hex_n(hex12)
    );

    always @(negedge clk) begin
        if (step_en) n_step <= n_step + 1;
        for (int k = 0; k < 4; k++) if (kp[k]) n_kp[k] <= n_kp[k] + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic press(input int k, input int n);
        key_n[k] = 1'b0;
        cyc(n);
        key_n[k] = 1'b1;
        cyc(16);
    endtask

    task automatic request(input logic [7:0] v);
        int n = 0;
        sw_load = 1'b0;
        cyc(4);
        pcv = v;
        sw_load = 1'b1;
        while (!valid && n < 10) begin
            cyc(1);
            n++;
        end
        chk("load_valid_rise", valid, 1);
        chk("load_val", val, v);
    endtask

    initial begin
        int s_step, s_kp, exp_kp [4], base [4];
        logic [DW-1:0] e8, e12;
        int sels [4] = '{9, 11, 12, 15};
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s_step, s_kp;
        int exp_kp [4], base [4];
        int sels [4];
        logic [DW-1:0] e8, e12;
        sels = '{9, 11, 12, 15};
        dv[0] = '{3, 18'h1234F, {7'h19, 7'h0E}};
        dv[1] = '{0, 18'h3FFA5, {7'h08, 7'h12}};
        dv[2] = '{7, 18'h00078, {7'h78, 7'h00}};
        dv[3] = '{5, 18'h2BC1D, {7'h79, 7'h21}};
        cyc(3);
        chk("rst_step_en", step_en, 0);
        chk("rst_key_pulse", kp, 0);
        chk("rst_valid", valid, 0);
        chk("rst_val", val, 0);
        chk("rst_leds", leds, 0);
        chk("rst_hex", hex, {seg_ref[0], seg_ref[0]});
        rst = 1'b0;
        cyc(2);

        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 12; c++) chan[c] = DW'($urandom);
            chan[dv[i].sel] = dv[i].val;
            sel8 = 3'(dv[i].sel);
            cyc(1);
            chk("tbl_leds", leds, dv[i].val);
            chk("tbl_hex", hex, dv[i].hex);
        end
        for (int i = 0; i < 4; i++) begin
            sel12 = 4'(sels[i]);
            cyc(1);
            chk("range_leds", leds12, sels[i] < 12 ? chan[sels[i]] : '0);
        end
        for (int i = 0; i < 30; i++) begin
            for (int c = 0; c < 12; c++) chan[c] = DW'($urandom);
            sel8 = 3'($urandom);
            sel12 = 4'($urandom);
            cyc(1);
            e8 = chan[sel8];
            e12 = sel12 < 12 ? chan[sel12] : '0;
            chk("rand_leds", leds, e8);
            chk("rand_hex", hex, {seg_ref[e8[7:4]], seg_ref[e8[3:0]]});
            chk("rand_leds12", leds12, e12);
        end

        s_step = n_step;
        s_kp = n_kp[0];
        for (int i = 0; i < 20; i++) begin
            key_n[0] = ((i / 3) % 2) != 0;
            cyc(1);
        end
        key_n[0] = 1'b0;
        cyc(12);
        key_n[0] = 1'b1;
        cyc(20);
        chk("bounce_steps", n_step - s_step, 1);
        chk("bounce_pulses", n_kp[0] - s_kp, 1);

        s_kp = n_kp[1];
        press(1, 7);
        chk("glitch7_pulses", n_kp[1] - s_kp, 0);
        press(1, 8);
        chk("hold8_pulses", n_kp[1] - s_kp, 1);

        s_step = n_step;
        for (int k = 0; k < 4; k++) begin
            base[k] = n_kp[k];
            exp_kp[k] = 0;
        end
        for (int r = 0; r < 14; r++) begin
            int k, n;
            k = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(10, 30);
                exp_kp[k]++;
            end else begin
                n = $urandom_range(1, 6);
            end
            press(k, n);
        end
        for (int k = 0; k < 4; k++) chk("rand_key_pulses", n_kp[k] - base[k], exp_kp[k]);
        chk("rand_key_steps", n_step - s_step, exp_kp[0]);

        s_step = n_step;
        s_kp = n_kp[0];
        request(8'hA5);
        key_n[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) sw_load = 1'b0;
            if (i == 8) begin
                pcv = 8'h3C;
                sw_load = 1'b1;
            end
            cyc(1);
            chk("pending_valid", valid, 1);
            chk("pending_val", val, 8'hA5);
        end
        key_n[0] = 1'b1;
        cyc(14);
        chk("pending_valid_late", valid, 1);
        ready = 1'b1;
        cyc(1);
        chk("ack_drop", valid, 0);
        ready = 1'b0;
        cyc(15);
        chk("no_second_request", valid, 0);
        chk("pending_steps", n_step - s_step, 0);
        chk("pending_pulses", n_kp[0] - s_kp, 1);

        ready = 1'b1;
        cyc(3);
        ready = 1'b0;
        chk("idle_ready", valid, 0);
        request(8'h5A);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        chk("ack2_drop", valid, 0);

`ifdef SYS_AUTO_RUN_EN
        sw_run = 1'b1;
        cyc(4);
        s_step = n_step;
        key_n[0] = 1'b0;
        cyc(30);
        chk("run_steps", n_step - s_step, 6);
        key_n[0] = 1'b1;
        sw_run = 1'b0;
        cyc(20);
        s_step = n_step;
        cyc(20);
        chk("run_stopped", n_step - s_step, 0);
`endif

        request(8'h77);
        chan[2] = 18'h3ABCD;
        sel8 = 3'd2;
        key_n[0] = 1'b0;
        cyc(5);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", valid, 0);
        chk("rst_mid_val", val, 0);
        chk("rst_mid_leds", leds, 0);
        chk("rst_mid_step", step_en, 0);
        chk("rst_mid_hex", hex, {seg_ref[0], seg_ref[0]});
        key_n[0] = 1'b1;
        sw_load = 1'b0;
        cyc(3);
        rst = 1'b0;
        s_step = n_step;
        s_kp = n_kp[0];
        cyc(20);
        chk("post_rst_pulses", n_kp[0] - s_kp, 0);
        chk("post_rst_steps", n_step - s_step, 0);
        chk("post_rst_valid", valid, 0);
        chk("post_rst_leds", leds, 18'h3ABCD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
